// File: rtl/pong_pkg.sv
// Shared pong encodings: match FSM states and winner codes.
package pong_pkg;

   typedef enum logic [1:0] {
      MATCH_END = 2'd0,
      POINT     = 2'd1,
      RALLY     = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } win_e;

endpackage

// File: rtl/match_ctrl_if.sv
// Ball-engine link: field events into the match controller, serve control out.
interface match_ctrl_if #(
   parameter int unsigned SPEED_W = 5
) ();

   logic               out_left;
   logic               out_right;
   logic               paddle_hit;
   logic [SPEED_W-1:0] speed;
   logic               ball_reset;
   logic               serve_left;

   modport master (
      input  out_left, out_right, paddle_hit,
      output speed, ball_reset, serve_left
   );

   modport slave (
      output out_left, out_right, paddle_hit,
      input  speed, ball_reset, serve_left
   );

endinterface

// File: rtl/freeze_timer.sv
// Down-counter for the freeze between points/matches; expire flags the last frozen cycle.
module freeze_timer #(
   parameter int unsigned FREEZE_W = 14,
   parameter int unsigned RST_VAL  = 16383
) (
   input  logic                game_clk,
   input  logic                reset_n,
   input  logic                load,
   input  logic [FREEZE_W-1:0] load_val,
   input  logic                skip,
   output logic [FREEZE_W-1:0] count,
   output logic                expire
);

   always_ff @(posedge game_clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= FREEZE_W'(RST_VAL);
      end else if (load) begin
         count <= load_val;
      end else if (skip) begin
         count <= FREEZE_W'(1);
      end else if (count != '0) begin
         count <= count - FREEZE_W'(1);
      end
   end

   assign expire = (count == FREEZE_W'(1));

endmodule

// File: rtl/match_ctrl.sv
// Pong match controller: scoring, serve freeze, rally speed-up and match end.
module match_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned SCORE_W       = 4,
   parameter int unsigned WIN_SCORE     = 9,
   parameter int unsigned WIN_BY_TWO    = 0,
   parameter int unsigned FREEZE_W      = 14,
   parameter int unsigned POINT_FREEZE  = 2000,
   parameter int unsigned MATCH_FREEZE  = 16383,
   parameter int unsigned SPEED_W       = 5,
   parameter int unsigned SERVE_SPEED   = 11,
   parameter int unsigned MAX_SPEED     = 15,
   parameter int unsigned HITS_PER_STEP = 4
) (
   input  logic               game_clk,
   input  logic               reset_n,
   input  logic               start,
   match_ctrl_if.master       ball,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic [1:0]         winner,
   output logic [1:0]         state
);

   localparam int unsigned SW1   = SCORE_W + 1;
   localparam int unsigned HIT_W = (HITS_PER_STEP < 2) ? 1 : $clog2(HITS_PER_STEP);

   if (WIN_SCORE > (2 ** SCORE_W) - 1) begin : g_bad_win_score
      $error("WIN_SCORE does not fit in SCORE_W");
   end
   if (POINT_FREEZE < 2 || MATCH_FREEZE < 2) begin : g_bad_freeze_min
      $error("freeze lengths must be at least 2");
   end
   if (POINT_FREEZE > (2 ** FREEZE_W) - 1 || MATCH_FREEZE > (2 ** FREEZE_W) - 1) begin : g_bad_freeze_w
      $error("freeze lengths do not fit in FREEZE_W");
   end
   if (SERVE_SPEED > MAX_SPEED || MAX_SPEED > (2 ** SPEED_W) - 1) begin : g_bad_speed
      $error("SERVE_SPEED must not exceed MAX_SPEED, which must fit in SPEED_W");
   end

   state_e             state_q, state_nxt;
   win_e               win_q, win_nxt;
   logic [SCORE_W-1:0] p1_q, p1_nxt, p2_q, p2_nxt;
   logic [SPEED_W-1:0] speed_q, speed_nxt;
   logic [HIT_W-1:0]   hit_q, hit_nxt;
   logic               serve_left_q, serve_left_nxt;
   logic               ball_reset_q, ball_reset_nxt;

   logic                frz_load, frz_skip, frz_expire;
   logic [FREEZE_W-1:0] frz_load_val, frz_count;

   logic               out_any;
   logic [SCORE_W-1:0] new_sc, opp_sc;
   logic               win_c;

   freeze_timer #(
      .FREEZE_W (FREEZE_W),
      .RST_VAL  (MATCH_FREEZE)
   ) u_freeze (
      .game_clk (game_clk),
      .reset_n  (reset_n),
      .load     (frz_load),
      .load_val (frz_load_val),
      .skip     (frz_skip),
      .count    (frz_count),
      .expire   (frz_expire)
   );

   // Scorer's saturated new score and the win test against the opponent.
   assign out_any = ball.out_left | ball.out_right;
   assign opp_sc  = ball.out_left ? p2_q : p1_q;
   assign new_sc  = ball.out_left ? ((p1_q == '1) ? p1_q : p1_q + SCORE_W'(1))
                                  : ((p2_q == '1) ? p2_q : p2_q + SCORE_W'(1));
   assign win_c   = ({1'b0, new_sc} >= SW1'(WIN_SCORE)) &&
                    ((WIN_BY_TWO == 0) || ({1'b0, new_sc} >= {1'b0, opp_sc} + SW1'(2)));

   always_ff @(posedge game_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= MATCH_END;
         win_q        <= WIN_NONE;
         p1_q         <= '0;
         p2_q         <= '0;
         speed_q      <= '0;
         hit_q        <= '0;
         serve_left_q <= 1'b0;
         ball_reset_q <= 1'b1;
      end else begin
         state_q      <= state_nxt;
         win_q        <= win_nxt;
         p1_q         <= p1_nxt;
         p2_q         <= p2_nxt;
         speed_q      <= speed_nxt;
         hit_q        <= hit_nxt;
         serve_left_q <= serve_left_nxt;
         ball_reset_q <= ball_reset_nxt;
      end
   end

   always_comb begin
      state_nxt      = state_q;
      win_nxt        = win_q;
      p1_nxt         = p1_q;
      p2_nxt         = p2_q;
      speed_nxt      = speed_q;
      hit_nxt        = hit_q;
      serve_left_nxt = serve_left_q;
      ball_reset_nxt = 1'b0;
      frz_load       = 1'b0;
      frz_load_val   = '0;
      frz_skip       = 1'b0;
      case (state_q)
         MATCH_END, POINT: begin
            frz_skip = start && (frz_count > FREEZE_W'(1));
            if (frz_expire) begin
               state_nxt      = RALLY;
               speed_nxt      = SPEED_W'(SERVE_SPEED);
               hit_nxt        = '0;
               ball_reset_nxt = 1'b1;
               if (state_q == MATCH_END) begin
                  p1_nxt  = '0;
                  p2_nxt  = '0;
                  win_nxt = WIN_NONE;
               end
            end
         end
         RALLY: begin
            if (out_any) begin
               if (ball.out_left) p1_nxt = new_sc;
               else               p2_nxt = new_sc;
               speed_nxt      = '0;
               serve_left_nxt = ball.out_left;
               frz_load       = 1'b1;
               if (win_c) begin
                  win_nxt      = ball.out_left ? WIN_P1 : WIN_P2;
                  state_nxt    = MATCH_END;
                  frz_load_val = FREEZE_W'(MATCH_FREEZE);
               end else begin
                  state_nxt    = POINT;
                  frz_load_val = FREEZE_W'(POINT_FREEZE);
               end
            end else if (ball.paddle_hit && (HITS_PER_STEP != 0)) begin
               // Every HITS_PER_STEP-th hit bumps the speed, capped at MAX_SPEED.
               if (32'(hit_q) + 32'd1 >= HITS_PER_STEP) begin
                  hit_nxt = '0;
                  if (speed_q < SPEED_W'(MAX_SPEED)) speed_nxt = speed_q + SPEED_W'(1);
               end else begin
                  hit_nxt = hit_q + HIT_W'(1);
               end
            end
         end
         default: state_nxt = MATCH_END;
      endcase
   end

   assign score_p1        = p1_q;
   assign score_p2        = p2_q;
   assign winner          = win_q;
   assign state           = state_q;
   assign ball.speed      = speed_q;
   assign ball.ball_reset = ball_reset_q;
   assign ball.serve_left = serve_left_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: two parameter sets driven in lockstep against a rule-level model.
module tb_match_ctrl;

   typedef struct {
      int smax, win_score, by_two, pf, mf, serve, maxs, hps;
   } prm_t;

   typedef struct {
      int frozen, over, freeze, s1, s2, win, speed, serve_left, hits, ball_reset;
   } mdl_t;

   logic game_clk = 1'b0;
   logic reset_n  = 1'b0;
   logic start = 1'b0, out_left = 1'b0, out_right = 1'b0, paddle_hit = 1'b0;

   int   tests = 0;
   int   fails = 0;
   bit   cmp_en = 1'b0;
   prm_t pa, pb;
   mdl_t ma, mb;

   logic [3:0] p1_a, p2_a, p1_b, p2_b;
   logic [1:0] win_a, st_a, win_b, st_b;

   always #5 game_clk = ~game_clk;

   match_ctrl_if #(.SPEED_W(5)) bus_a ();
   match_ctrl_if #(.SPEED_W(5)) bus_b ();

   assign bus_a.out_left   = out_left;
   assign bus_a.out_right  = out_right;
   assign bus_a.paddle_hit = paddle_hit;
   assign bus_b.out_left   = out_left;
   assign bus_b.out_right  = out_right;
   assign bus_b.paddle_hit = paddle_hit;

   match_ctrl #(
      .SCORE_W(4), .WIN_SCORE(9), .WIN_BY_TWO(0), .FREEZE_W(14),
      .POINT_FREEZE(5), .MATCH_FREEZE(8), .SPEED_W(5),
      .SERVE_SPEED(11), .MAX_SPEED(15), .HITS_PER_STEP(4)
   ) dut_a (
      .game_clk(game_clk), .reset_n(reset_n), .start(start), .ball(bus_a.master),
      .score_p1(p1_a), .score_p2(p2_a), .winner(win_a), .state(st_a)
   );

   match_ctrl #(
      .SCORE_W(4), .WIN_SCORE(3), .WIN_BY_TWO(1), .FREEZE_W(14),
      .POINT_FREEZE(5), .MATCH_FREEZE(8), .SPEED_W(5),
      .SERVE_SPEED(14), .MAX_SPEED(15), .HITS_PER_STEP(2)
   ) dut_b (
      .game_clk(game_clk), .reset_n(reset_n), .start(start), .ball(bus_b.master),
      .score_p1(p1_b), .score_p2(p2_b), .winner(win_b), .state(st_b)
   );

   function automatic mdl_t mdl_reset(prm_t p);
      mdl_t m;
      m.frozen = 1; m.over = 1; m.freeze = p.mf;
      m.s1 = 0; m.s2 = 0; m.win = 0; m.speed = 0;
      m.serve_left = 0; m.hits = 0; m.ball_reset = 1;
      return m;
   endfunction

   // One game_clk edge of the match rules.
   function automatic mdl_t step(mdl_t m, prm_t p, logic st, logic ol, logic orr, logic ph);
      mdl_t n;
      int   ns, opp;
      n = m;
      n.ball_reset = 0;
      if (m.frozen != 0) begin
         if (m.freeze == 1) begin
            n.frozen = 0; n.freeze = 0; n.speed = p.serve; n.hits = 0; n.ball_reset = 1;
            if (m.over != 0) begin
               n.s1 = 0; n.s2 = 0; n.win = 0; n.over = 0;
            end
         end else if (st) begin
            n.freeze = 1;
         end else begin
            n.freeze = m.freeze - 1;
         end
      end else if (ol || orr) begin
         ns  = ol ? m.s1 : m.s2;
         opp = ol ? m.s2 : m.s1;
         if (ns < p.smax) ns++;
         if (ol) n.s1 = ns; else n.s2 = ns;
         n.speed = 0;
         n.serve_left = ol ? 1 : 0;
         n.frozen = 1;
         if (ns >= p.win_score && (p.by_two == 0 || ns - opp >= 2)) begin
            n.win = ol ? 1 : 2; n.over = 1; n.freeze = p.mf;
         end else begin
            n.over = 0; n.freeze = p.pf;
         end
      end else if (ph && p.hps > 0) begin
         n.hits++;
         if (n.hits == p.hps) begin
            n.hits = 0;
            if (n.speed < p.maxs) n.speed++;
         end
      end
      return n;
   endfunction

   function automatic int st_code(mdl_t m);
      return (m.frozen == 0) ? 2 : ((m.over != 0) ? 0 : 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input int exp);
      tests++;
      if (got !== 32'(exp)) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic cmp(input string t, input mdl_t m, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [1:0] w, input logic [1:0] st, input logic [4:0] sp,
                      input logic br, input logic sl);
      chk({t, ".score_p1"},   32'(s1), m.s1);
      chk({t, ".score_p2"},   32'(s2), m.s2);
      chk({t, ".winner"},     32'(w),  m.win);
      chk({t, ".state"},      32'(st), st_code(m));
      chk({t, ".speed"},      32'(sp), m.speed);
      chk({t, ".ball_reset"}, 32'(br), m.ball_reset);
      chk({t, ".serve_left"}, 32'(sl), m.serve_left);
   endtask

   always @(posedge game_clk or negedge reset_n) begin
      if (!reset_n) begin
         ma = mdl_reset(pa);
         mb = mdl_reset(pb);
      end else begin
         ma = step(ma, pa, start, out_left, out_right, paddle_hit);
         mb = step(mb, pb, start, out_left, out_right, paddle_hit);
      end
   end

   always @(negedge game_clk) begin
      if (reset_n && cmp_en) begin
         cmp("A", ma, p1_a, p2_a, win_a, st_a, bus_a.speed, bus_a.ball_reset, bus_a.serve_left);
         cmp("B", mb, p1_b, p2_b, win_b, st_b, bus_b.speed, bus_b.ball_reset, bus_b.serve_left);
      end
   end

   task automatic tick();
      @(posedge game_clk);
      #1;
   endtask

   task automatic serve();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10 && !(st_a == 2'd2 && st_b == 2'd2); i++) tick();
      chk("serve_reached", 32'(st_a == 2'd2 && st_b == 2'd2), 1);
   endtask

   task automatic point(input bit left);
      if (!(st_a == 2'd2 && st_b == 2'd2)) serve();
      out_left  = left;
      out_right = !left;
      tick();
      out_left  = 1'b0;
      out_right = 1'b0;
   endtask

   initial begin
      pa = '{smax: 15, win_score: 9, by_two: 0, pf: 5, mf: 8, serve: 11, maxs: 15, hps: 4};
      pb = '{smax: 15, win_score: 3, by_two: 1, pf: 5, mf: 8, serve: 14, maxs: 15, hps: 2};
      ma = mdl_reset(pa);
      mb = mdl_reset(pb);
      cmp_en = 1'b1;

      // Reset values and serve timing after release.
      repeat (2) tick();
      chk("rst.state", 32'(st_a), 0);
      chk("rst.speed", 32'(bus_a.speed), 0);
      chk("rst.ball_reset", 32'(bus_a.ball_reset), 1);
      chk("rst.score_p1", 32'(p1_a), 0);
      chk("rst.winner", 32'(win_a), 0);
      reset_n = 1'b1;
      tick();
      chk("rel.ball_reset_drop", 32'(bus_a.ball_reset), 0);
      repeat (6) tick();
      chk("serve.edge7_state", 32'(st_a), 0);
      tick();
      chk("serve.edge8_state", 32'(st_a), 2);
      chk("serve.edge8_speed_a", 32'(bus_a.speed), 11);
      chk("serve.edge8_speed_b", 32'(bus_b.speed), 14);
      chk("serve.edge8_ball_reset", 32'(bus_a.ball_reset), 1);
      chk("serve.edge8_score_p2", 32'(p2_a), 0);

      // Point to P1, then start cuts the freeze short.
      point(1'b1);
      chk("pt.score_p1", 32'(p1_a), 1);
      chk("pt.speed", 32'(bus_a.speed), 0);
      chk("pt.serve_left", 32'(bus_a.serve_left), 1);
      chk("pt.state", 32'(st_a), 1);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start.freeze1_state", 32'(st_a), 1);
      tick();
      chk("start.rally_state", 32'(st_a), 2);
      chk("start.ball_reset", 32'(bus_a.ball_reset), 1);

      // Win-by-two on B: 1-0 -> 2-2 -> 3-2 (no win) -> 4-2 (win).
      point(1'b0);
      point(1'b0);
      point(1'b1);
      point(1'b1);
      chk("w2.p1_3_state", 32'(st_b), 1);
      chk("w2.p1_3_winner", 32'(win_b), 0);
      point(1'b1);
      chk("w2.p1_4_winner", 32'(win_b), 1);
      chk("w2.p1_4_state", 32'(st_b), 0);
      chk("w2.p1_4_score", 32'(p1_b), 4);
      serve();
      chk("w2.clear_p1", 32'(p1_b), 0);
      chk("w2.clear_p2", 32'(p2_b), 0);
      chk("w2.clear_winner", 32'(win_b), 0);
      chk("w2.a_keeps_p1", 32'(p1_a), 4);

      // Speed-up: B steps every 2 hits from 14 and caps at 15; A steps after 4.
      for (int i = 0; i < 6; i++) begin
         paddle_hit = 1'b1;
         tick();
         if (i == 1) chk("hits.b_after2", 32'(bus_b.speed), 15);
      end
      paddle_hit = 1'b0;
      chk("hits.b_after6", 32'(bus_b.speed), 15);
      chk("hits.a_after6", 32'(bus_a.speed), 12);

      // Both outs plus a hit in one cycle: only P1 scores.
      out_left = 1'b1; out_right = 1'b1; paddle_hit = 1'b1;
      tick();
      out_left = 1'b0; out_right = 1'b0; paddle_hit = 1'b0;
      chk("both.b_p1", 32'(p1_b), 1);
      chk("both.b_p2", 32'(p2_b), 0);
      chk("both.a_p1", 32'(p1_a), 5);
      chk("both.b_speed", 32'(bus_b.speed), 0);

      // Random play checked every cycle by the model.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 31));
         start      = ($urandom_range(0, 15) == 0);
         out_left   = (r == 0 || r == 2);
         out_right  = (r == 1 || r == 2);
         paddle_hit = ($urandom_range(0, 2) == 0);
         tick();
      end
      start = 1'b0; out_left = 1'b0; out_right = 1'b0; paddle_hit = 1'b0;

      // Fresh match to 5-4, then asynchronous reset mid-rally.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 9; i++) point(i % 2 == 0);
      serve();
      chk("mid.b_p1", 32'(p1_b), 5);
      chk("mid.b_p2", 32'(p2_b), 4);
      chk("mid.b_state", 32'(st_b), 2);
      @(posedge game_clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst.score_p1", 32'(p1_b), 0);
      chk("arst.score_p2", 32'(p2_b), 0);
      chk("arst.speed", 32'(bus_b.speed), 0);
      chk("arst.ball_reset", 32'(bus_b.ball_reset), 1);
      chk("arst.winner", 32'(win_b), 0);
      chk("arst.state", 32'(st_a), 0);
      tick();
      reset_n = 1'b1;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Parametrised match controller for pong: owns score, serve timing, rally speed-up and match termination, and drives the ball engine's `speed`/`ball_reset` from the ball engine's `out_left`/`out_right`/`paddle_hit` events. It supersedes the fixed first-to-9 game loop with configurable:
- target score, optional win-by-two, freeze lengths;
- serve speed and progressive speed-up.

It sits between the input stage (debounced `start`) and the ball engine, and feeds the score display.

## Interface

Parameters:
- `SCORE_W`, 4: score counter width
- `WIN_SCORE`, 9: points needed to win; must be ≤ 2^SCORE_W−1
- `WIN_BY_TWO`, 0: 1 = winner must also lead by ≥2
- `FREEZE_W`, 14: freeze counter width
- `POINT_FREEZE`, 2000: freeze cycles after a point (≥2)
- `MATCH_FREEZE`, 16383: freeze cycles after reset/match end (≥2)
- `SPEED_W`, 5: speed width (unsigned magnitude)
- `SERVE_SPEED`, 11: speed at serve; must be ≤ MAX_SPEED
- `MAX_SPEED`, 15: speed ceiling
- `HITS_PER_STEP`, 4: paddle hits per +1 speed; 0 disables speed-up

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `game_clk` in 1: 1 kHz game clock
  - `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: debounced start; cuts a freeze short
- `out_left` in 1: ball left the field on the left → point to P1
- `out_right` in 1: ball left the field on the right → point to P2
- `paddle_hit` in 1: one-cycle pulse per paddle contact
- `speed` out SPEED_W: ball speed to ball engine
- `ball_reset` out 1: recentre ball
- `serve_left` out 1: 1 = next serve travels left
- `score_p1` out SCORE_W: P1 score
- `score_p2` out SCORE_W: P2 score
- `winner` out 2: 00 none, 01 P1, 10 P2
- `state` out 2: current FSM state (debug/display)

## Operation

States: MATCH_END, POINT, RALLY.

Reset (async, `reset_n`=0) forces:
- state=MATCH_END, freeze=MATCH_FREEZE
- scores=0, winner=00, speed=0, serve_left=0, hit count=0
- ball_reset=1

MATCH_END / POINT (frozen):
- freeze decrements by 1 per cycle.
- `start`=1 with freeze>1 loads freeze=1.
- `out_*` and `paddle_hit` are ignored.
- At the edge where freeze==1, all of the following happen together:
  - freeze←0, state←RALLY, speed←SERVE_SPEED, hit count←0, ball_reset←1.
  - If leaving MATCH_END, also scores←0 and winner←00.

RALLY:
- `start` is ignored.
- `out_left` has priority over `out_right`.
- On an out event:
  - The scorer's score is incremented, saturating at 2^SCORE_W−1.
  - speed←0.
  - serve_left←1 on `out_left`, 0 on `out_right`.
- Win test uses the new score: score ≥ WIN_SCORE, and, when WIN_BY_TWO=1, new score − opponent ≥ 2.
  - Win: winner set, state←MATCH_END, freeze←MATCH_FREEZE.
  - No win: state←POINT, freeze←POINT_FREEZE.
- `paddle_hit` with no out event in the same cycle: hit count+1.
  - When the count reaches HITS_PER_STEP, the count←0 and speed←min(speed+1, MAX_SPEED).
  - HITS_PER_STEP=0: speed never changes during a rally.
- `paddle_hit` coincident with an out event is discarded.

## Timing

- All outputs are registered; no combinational input→output paths.
- ball_reset deasserts on the first `game_clk` edge after reset release and is otherwise a single-cycle pulse.
- Latency from an out event to the score/speed/state update: 1 cycle.
- Serve timing:
  - Frozen state entered with freeze=N and no `start`: the RALLY entry edge is the N-th edge after entry.
  - speed=SERVE_SPEED and ball_reset=1 are visible together on that edge.
- `start` latency: with freeze>1, freeze=1 on the next edge and RALLY one edge later.
- Reset asserted mid-rally or mid-freeze takes effect immediately (asynchronously); no pending event survives.

## Structure

- Shared package `pong_pkg` holds:
  - state encoding typedef: MATCH_END=0, POINT=1, RALLY=2
  - winner codes: WIN_NONE, WIN_P1, WIN_P2
- Sub-module `freeze_timer` (parametrised by FREEZE_W):
  - inputs: load, load value, skip
  - outputs: count, one-cycle `expire` at count==1
- Elaboration-time assertions check the parameter constraints given above.

## Test plan

- Reset release, no `start`, POINT_FREEZE=5, MATCH_FREEZE=8 → RALLY entered on edge 8; speed=11 and ball_reset=1 on that same edge; scores 0.
- In RALLY, `out_left` → score_p1=1, speed=0, serve_left=1, state=POINT; `start` pulse 2 cycles later → RALLY within 2 cycles.
- WIN_SCORE=3, WIN_BY_TWO=1, score 2–2; P1 scores to 3–2 → POINT; P1 scores to 4–2 → winner=01, MATCH_END; at expiry scores and winner clear.
- HITS_PER_STEP=2, SERVE_SPEED=14, MAX_SPEED=15: 6 hits → speed 15, holding at 15.
- `out_left` and `out_right` in the same cycle → only score_p1 increments; a coincident `paddle_hit` has no effect on speed.
- `reset_n` asserted mid-rally at score 5–4 → outputs immediately reset values (scores 0, speed 0, ball_reset 1, winner 00).
